// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encodings, requester IDs and the default starvation limit.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    // A non-zero limit guarantees instruction fetch is eventually served
    // even under a continuous load/store stream.
    localparam int DEF_STARVE_LIMIT = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch (I) and load/store (D)
// requesters. D is preferred unless fetch has been passed over
// STARVE_LIMIT times in a row. A requester completing at this edge is
// masked, since its request line is still high for the finished access.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int SW           = 2
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic          mask_i,
    input  logic          mask_d,
    input  logic [SW-1:0] streak,
    output logic          win_vld,
    output src_t          win_src
);

    logic i_cand;
    logic d_cand;
    logic starve;

    // Pick D by default; hand the slot to I once its wait streak saturates.
    always_comb begin
        i_cand  = if_req & ~mask_i;
        d_cand  = d_req & ~mask_d;
        starve  = (STARVE_LIMIT != 0) && (streak == SW'(STARVE_LIMIT));
        win_vld = i_cand | d_cand;
        win_src = SRC_I;
        if (d_cand && !(starve && i_cand))
            win_src = SRC_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. Holds one access in flight, issues back-to-back grants on
// the completing edge, and raises stall_if/stall_mem for the hazard unit.
// Optional build macro: MEM_ARB_TIMEOUT_EN enables a watchdog that aborts
// an access after TIMEOUT_CYCLES request cycles without mem_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  bus_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t        state_q, state_d;
    logic [SW-1:0] streak;
    logic          busy;
    logic          timeout;
    logic          complete;
    logic          done_i;
    logic          done_d;
    logic          arb_en;
    logic          win_vld;
    src_t          win_src;
    logic          grant_i;
    logic          grant_d;

    assign busy     = (state_q != ST_IDLE);
    assign complete = busy & (mem_ready | timeout);
    assign done_i   = complete & (state_q == ST_BUSY_I);
    assign done_d   = complete & (state_q == ST_BUSY_D);
    assign arb_en   = (state_q == ST_IDLE) | complete;
    assign grant_i  = arb_en & win_vld & (win_src == SRC_I);
    assign grant_d  = arb_en & win_vld & (win_src == SRC_D);

    // Stall while a request is pending and its access is not finishing now.
    assign stall_if  = if_req & ~done_i;
    assign stall_mem = d_req & ~done_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .mask_i  (done_i),
        .mask_d  (done_d),
        .streak  (streak),
        .win_vld (win_vld),
        .win_src (win_src)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: follow the winner on any arbitration edge, else hold.
    always_comb begin
        state_d = state_q;
        if (arb_en) begin
            if (!win_vld)
                state_d = ST_IDLE;
            else if (win_src == SRC_D)
                state_d = ST_BUSY_D;
            else
                state_d = ST_BUSY_I;
        end
    end

    // Memory-side request registers, completion pulses and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= done_i;
            d_valid  <= done_d;
            if (done_i)
                if_rdata <= timeout ? '0 : mem_rdata;
            if (done_d && (timeout || !mem_we))
                d_rdata <= timeout ? '0 : mem_rdata;
            if (arb_en) begin
                mem_req <= win_vld;
                if (!win_vld)
                    mem_we <= 1'b0;
                if (grant_i) begin
                    mem_addr <= if_addr;
                    mem_we   <= 1'b0;
                end
                if (grant_d) begin
                    mem_addr  <= d_addr;
                    mem_we    <= d_we;
                    mem_wdata <= d_wdata;
                end
            end
        end
    end

    // Count D grants that passed over a waiting fetch; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset || !if_req || grant_i)
            streak <= '0;
        else if (grant_d && (streak != SW'(STARVE_LIMIT)))
            streak <= streak + SW'(1);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wait_cnt;

    assign timeout = busy & ~mem_ready & (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog: cycles of the current access spent waiting on mem_ready.
    always_ff @(posedge clk) begin
        if (reset || !busy || complete)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + WW'(1);
    end

    // Abort pulse, aligned with the aborted requester's valid pulse.
    always_ff @(posedge clk) begin
        if (reset)
            bus_err <= 1'b0;
        else
            bus_err <= timeout;
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
`endif

endmodule
